xbus_uart_tx: RTL
=================

Name: xbus_uart_tx

Overview:
- Transmit-only UART peripheral; occupies the spare fourth xbus slave slot (chip-select bit 3) beside rom, ram and sw_led.
- Core writes bytes into a small TX FIFO over xbus. A baud-rate FSM serialises them 8N1, LSB first, on the `tx` pin.
- Gives firmware console output without polling per bit.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- xbus_cs  input  1  slave select from the xbus decoder
- xbus_we  input  1  write strobe, qualified by xbus_cs
- xbus_be  input  4  byte enables
- xbus_addr  input  32  byte address; only [3:2] decoded
- xbus_wdata  input  32  write data
- xbus_rdata  output  32  read data, combinational
- tx  output  1  serial line, idles high

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Register map, word offset = xbus_addr[3:2]:
  - 0 TXDATA: write pushes wdata[7:0], only when be[0]=1. Reads 0.
  - 1 STATUS (RO except bit3):
    - bit0 full; bit1 empty; bit2 busy (FSM not IDLE)
    - bit3 overflow, sticky; write 1 with be[0] clears it
    - bits[7:4] FIFO count; all other bits 0.
  - 2 BAUDDIV: bits[15:0] RW, honouring be[1:0]. Reads zero-extended.
  - 3 CTRL: see Optional Feature; otherwise reads 0 and writes are ignored.
- Writes take effect on the clk edge where xbus_cs & xbus_we. Reads are combinational. xbus_rdata=0 when xbus_cs=0.
- Reset values: tx=1; FIFO empty; overflow=0; BAUDDIV=DEFAULT_DIV; FSM=IDLE; xbus_rdata combinationally 0 unless selected.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when FIFO non-empty. On that same edge: pop the head byte into the shift register, latch BAUDDIV into a bit-period register, drive tx=0 (registered).
  - Latency: tx goes low on the edge after the TXDATA write edge (1 cycle).
  - Each state lasts exactly P cycles, where P = latched BAUDDIV, and a latched value of 0 is treated as 1. A down-counter reloads to P-1 at every bit boundary.
  - START -> DATA: 8 bits, LSB first, bit index 0..7.
  - DATA -> STOP after bit 7; tx=1 for P cycles.
  - STOP -> START if FIFO non-empty (pop + latch on the same edge, back-to-back frames of exactly 10*P cycles); otherwise STOP -> IDLE.
- BAUDDIV writes during a frame do not disturb it; they apply from the next frame's start.
- Push to a full FIFO: data dropped, overflow set, FIFO unchanged.
- Push and pop on the same edge when full: the pop frees space, so the push succeeds and count stays unchanged. Push and pop on the same edge when not full: both occur.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Reset mid-frame: frame aborted, tx=1 the following cycle, FIFO flushed.

Optional Feature:
- Macro: XBUS_UART_TX_IRQ_EN.
- When defined:
  - Adds output `irq` (1 bit, reset 0, registered).
  - CTRL bit0 = IE (RW, reset 0).
  - irq = IE & FIFO empty & FSM IDLE, updated every cycle.
- When undefined: no irq port; CTRL reads 0 and writes are ignored.

Decomposition:
- Shared defines header holds:
  - register offsets (TXDATA/STATUS/BAUDDIV/CTRL)
  - STATUS bit indices
  - FSM state encodings
  - slave slot index 3 for the xbus decoder and soc rdata mux
- One sub-module: xbus_uart_fifo, a synchronous FIFO (push/pop/full/empty/count, parameter DEPTH, 8-bit data).
- FSM, baud counter and register decode stay in the top module.

Test Plan:
- BAUDDIV=4, write TXDATA 0x55:
  - tx low 1 cycle after the write edge.
  - Sequence 0,1,0,1,0,1,0,1,0,1 (start, bits LSB first, stop), 4 cycles each, 40 cycles total.
  - busy=1 throughout, then empty=1, busy=0.
- BAUDDIV=2, four back-to-back writes 0x01,0x02,0x03,0x04:
  - Frames contiguous, 20 cycles each, no idle gap.
  - STATUS count reads 3 immediately after the 4th write (first byte already popped).
- BAUDDIV=8, five writes while the first frame is in flight: all accepted (1 in shift register plus 4 in FIFO). Sixth write sets overflow and the byte is never sent. Write STATUS=0x8 clears overflow.
- Write TXDATA 0xAA with be=4'b1110: no push, count 0, tx stays 1. Read CTRL with the macro undefined -> 0.
- Assert rst during DATA bit 3 of 0xF0 with 2 bytes queued:
  - tx=1 the cycle after reset.
  - STATUS=0x2 (empty only); BAUDDIV reads DEFAULT_DIV.
- With XBUS_UART_TX_IRQ_EN, IE=1, send 0x41:
  - irq=0 during the frame.
  - irq rises the cycle after the STOP->IDLE transition.
  - Clearing IE drops irq the next cycle.

Source files
------------

// File: rtl/xbus_uart_tx_pkg.sv
// Shared definitions for the xbus transmit-only UART: register map, STATUS bits,
// FSM encoding and the decoder slot this peripheral occupies.
package xbus_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int XBUS_SLOT_UART = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A programmed divisor of zero would stall the line, so it behaves as one.
    function automatic logic [15:0] eff_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/xbus_uart_tx_if.sv
// xbus slave-slot signal bundle; the decoder/core side is the master.
interface xbus_uart_tx_if;
    logic        cs;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, we, be, addr, wdata, input rdata);
    modport slave  (input cs, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/xbus_uart_fifo.sv
// Synchronous byte FIFO; a pop on the same edge frees room for a push when full.
module xbus_uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xbus_uart_tx.sv
// Transmit-only 8N1 UART on xbus slot 3: TX FIFO, baud-rate FSM and register decode.
// Define XBUS_UART_TX_IRQ_EN to add the CTRL.IE bit and the registered irq output.
module xbus_uart_tx
    import xbus_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic           clk,
    input  logic           rst,
    xbus_uart_tx_if.slave  xbus,
    output logic           tx
`ifdef XBUS_UART_TX_IRQ_EN
    ,
    output logic           irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   period;
    logic [15:0]   baud_div;
    logic [15:0]   next_period;
    logic          overflow;

    logic          wr_en;
    logic [1:0]    reg_sel;
    logic          push;
    logic          pop;
    logic          ovf_clear;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_dout;
    logic [3:0]    count_field;
    logic          unused;

    assign wr_en       = xbus.cs & xbus.we;
    assign reg_sel     = xbus.addr[3:2];
    assign push        = wr_en && (reg_sel == REG_TXDATA) && xbus.be[0];
    assign ovf_clear   = wr_en && (reg_sel == REG_STATUS) && xbus.be[0] && xbus.wdata[STAT_OVF];
    assign next_period = eff_period(baud_div);
    assign count_field = 4'(fifo_count);
    assign unused      = ^{xbus.addr[31:4], xbus.addr[1:0], xbus.wdata[31:16], xbus.be[3:2]};

    // A new frame is loaded from idle, or straight out of the last STOP cycle.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            pop = (state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == 16'd0));
        end
    end

    xbus_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (xbus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div <= DEFAULT_DIV;
        end else if (wr_en && (reg_sel == REG_BAUDDIV)) begin
            if (xbus.be[0]) baud_div[7:0]  <= xbus.wdata[7:0];
            if (xbus.be[1]) baud_div[15:8] <= xbus.wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    // The bit period is captured at frame start so BAUDDIV writes never bend a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            shift    <= 8'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= 16'd0;
            period   <= 16'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_START;
                        shift    <= fifo_dout;
                        period   <= next_period;
                        baud_cnt <= next_period - 16'd1;
                        tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_cnt == 16'd0) begin
                        state    <= ST_DATA;
                        bit_idx  <= 3'd0;
                        baud_cnt <= period - 16'd1;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= period - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (pop) begin
                            state    <= ST_START;
                            shift    <= fifo_dout;
                            period   <= next_period;
                            baud_cnt <= next_period - 16'd1;
                            tx       <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

`ifdef XBUS_UART_TX_IRQ_EN
    logic ie;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == REG_CTRL) && xbus.be[0]) begin
                ie <= xbus.wdata[0];
            end
            irq <= ie & fifo_empty & (state == ST_IDLE);
        end
    end
`endif

    always_comb begin
        xbus.rdata = 32'd0;
        if (xbus.cs) begin
            case (reg_sel)
                REG_STATUS: begin
                    xbus.rdata[STAT_FULL]                    = fifo_full;
                    xbus.rdata[STAT_EMPTY]                   = fifo_empty;
                    xbus.rdata[STAT_BUSY]                    = (state != ST_IDLE);
                    xbus.rdata[STAT_OVF]                     = overflow;
                    xbus.rdata[STAT_CNT_LSB+3:STAT_CNT_LSB]  = count_field;
                end
                REG_BAUDDIV: xbus.rdata = {16'd0, baud_div};
`ifdef XBUS_UART_TX_IRQ_EN
                REG_CTRL:    xbus.rdata = {31'd0, ie};
`endif
                default:     xbus.rdata = 32'd0;
            endcase
        end
    end

endmodule
